bp_nonsynth_if_monitor: RTL
===========================

// Module: bp_nonsynth_if_monitor
// PURPOSE
// - Parametrised runtime checker for N ready/valid channels (LCE req/cmd/resp, mem msg, FE queue/cmd).
// - Turns elaboration-time width checks into cycle-level protocol checks.
// - Flags dropped valids, payload changes while stalled, and stall timeouts; counts handshakes per channel.
// - Nonsynth; instantiated in testbench tops beside the parameter checker, observe-only.
// PARAMETERS
// - num_chan_p     3     number of monitored channels
// - data_width_p   64    payload width per channel, bits
// - timeout_p      1024  max consecutive stalled cycles; 0 disables timeout check
// - count_width_p  32    per-channel handshake counter width
// PORTS
// - clk_i          in   1                          clock
// - reset_i        in   1                          synchronous, active-high reset
// - v_i            in   num_chan_p                 per-channel valid
// - ready_and_i    in   num_chan_p                 per-channel ready
// - data_i         in   num_chan_p*data_width_p    payloads; channel i at [i*data_width_p+:data_width_p]
// - error_o        out  1                          sticky: a violation was detected
// - err_chan_o     out  `BSG_SAFE_CLOG2(num_chan_p) channel of first violation
// - err_code_o     out  2                          0 none, 1 drop, 2 change, 3 timeout
// - msg_count_o    out  num_chan_p*count_width_p   handshakes per channel, saturating
// BEHAVIOUR
// - Reset: all outputs 0; per-channel FSMs in IDLE; captured data and stall counters cleared.
// - Reset asserted mid-transaction abandons it silently: no error raised, counts cleared.
// - Inputs are ignored while reset_i is high.
// - Handshake: v_i & ready_and_i in the same cycle; msg_count increments next cycle.
// - msg_count saturates at all-ones and never wraps.
// - Per-channel FSM, IDLE/PEND:
//   - IDLE, v & ready:           stay IDLE, count++.
//   - IDLE, v & ~ready:          go PEND, capture data, stall=1.
//   - PEND, ~v:                  DROP violation, go IDLE.
//   - PEND, v, data!=captured:   CHANGE violation, recapture, stall=1, stay PEND (or IDLE if ready).
//   - PEND, v, data==cap, ready: count++, go IDLE.
//   - PEND, v, data==cap, ~ready: stall++ (saturating).
// - Timeout: when stall reaches timeout_p while in PEND and unaccepted, raise TIMEOUT once per transaction.
// - Timeout has no effect when timeout_p==0.
// - Error latency: violation in cycle t -> error_o/err_chan_o/err_code_o valid at t+1.
// - Error outputs are sticky until reset; only the first violation is recorded.
// - Simultaneous violations: lowest channel index wins.
// - Within one channel, DROP outranks TIMEOUT.
// - Counting and FSMs continue after the first error.
// - Every violation prints $display("[%t] if_monitor ch%0d code%0d").
// CONFIGURATION
// - BP_IF_MONITOR_FATAL_EN defined:
//   - $fatal on the cycle the first error latches (t+1), after the display.
// - Undefined (default):
//   - Error is latched and reported only.
//   - Simulation continues; the bench checks error_o at end of test.
// TESTING
// - num_chan_p=3, timeout_p=4:
//   - ch0: 5 back-to-back handshakes -> msg_count ch0=5, error_o=0.
//   - ch1: v=1, data=0xA5, ready=0 for 3 cycles, then ready=1 -> count ch1=1, no error.
//   - ch2: v high, ready low, 1 cycle, then v=0 -> next cycle error_o=1, chan=2, code=1.
//   - ch0 stalled with data 0x11, changed to 0x22 -> error code=2, chan=0; later violations leave outputs unchanged.
//   - ch1: stalled 4 cycles -> error code=3 cycle after the 4th stall.
//     - Same cycle as a ch2 drop -> chan=1 (lowest index wins).
//   - count_width_p=3: 9 handshakes -> count=7.
//   - reset_i mid-stall -> all outputs 0, no error.
//   - FATAL_EN build: drop on ch0 -> sim terminates with $fatal.

Source files
------------

// File: rtl/bp_nonsynth_if_monitor.sv
// bp_nonsynth_if_monitor
//   Observe-only runtime checker for num_chan_p ready/valid channels.
//   Detects these protocol violations:
//     - a valid that is dropped while stalled,
//     - a payload that changes while stalled,
//     - a stall that lasts too long.
//   It also counts handshakes per channel, and each counter saturates.
//   The first violation is latched and held until reset.
//
// Ports
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   v_i          per-channel valid
//   ready_and_i  per-channel ready
//   data_i       payloads, channel i at [i*data_width_p +: data_width_p]
//   error_o      sticky violation flag
//   err_chan_o   channel of the first violation
//   err_code_o   code of the first violation: 0 none, 1 drop, 2 change, 3 timeout
//   msg_count_o  saturating handshake count per channel
//
// Build option
//   BP_IF_MONITOR_FATAL_EN  when defined, the monitor calls $fatal when the
//                           first error latches. Without it, the error is
//                           only latched and displayed.
module bp_nonsynth_if_monitor #(
    parameter int num_chan_p    = 3,
    parameter int data_width_p  = 64,
    parameter int timeout_p     = 1024,
    parameter int count_width_p = 32,
    localparam int ChanW        = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_chan_p-1:0]                 v_i,
    input  logic [num_chan_p-1:0]                 ready_and_i,
    input  logic [num_chan_p*data_width_p-1:0]    data_i,
    output logic                                  error_o,
    output logic [ChanW-1:0]                      err_chan_o,
    output logic [1:0]                            err_code_o,
    output logic [num_chan_p*count_width_p-1:0]   msg_count_o
);

    localparam int StallW = (timeout_p < 1) ? 1 : $clog2(timeout_p + 1);
    localparam logic [StallW-1:0] TimeoutV = StallW'(timeout_p);

    localparam logic [1:0] CodeNone    = 2'd0;
    localparam logic [1:0] CodeDrop    = 2'd1;
    localparam logic [1:0] CodeChange  = 2'd2;
    localparam logic [1:0] CodeTimeout = 2'd3;

    typedef enum logic {IDLE, PEND} state_e;

    logic [num_chan_p-1:0][1:0] chan_code;

    for (genvar i = 0; i < num_chan_p; i++) begin : g_chan
        state_e                   state_q, state_d;
        logic [data_width_p-1:0]  cap_q, cap_d;
        logic [StallW-1:0]        stall_q, stall_d;
        logic                     to_q, to_d;     // timeout already raised for this transaction
        logic [count_width_p-1:0] cnt_q, cnt_d;
        logic [1:0]               code;
        logic                     inc;
        logic                     v, rdy;
        logic [data_width_p-1:0]  d;

        assign v   = v_i[i];
        assign rdy = ready_and_i[i];
        assign d   = data_i[i*data_width_p +: data_width_p];

        always_comb begin
            state_d = state_q;
            cap_d   = cap_q;
            stall_d = stall_q;
            to_d    = to_q;
            code    = CodeNone;
            inc     = 1'b0;
            case (state_q)
                IDLE: begin
                    if (v) begin
                        if (rdy) begin
                            inc = 1'b1;
                        end else begin
                            state_d = PEND;
                            cap_d   = d;
                            stall_d = StallW'(1);
                            to_d    = 1'b0;
                        end
                    end
                end
                PEND: begin
                    if (!v) begin
                        code    = CodeDrop;
                        state_d = IDLE;
                        stall_d = '0;
                        to_d    = 1'b0;
                    end else if (d != cap_q) begin
                        // A changed payload is treated as a new transaction.
                        code    = CodeChange;
                        cap_d   = d;
                        stall_d = StallW'(1);
                        to_d    = 1'b0;
                        if (rdy) begin
                            inc     = 1'b1;
                            state_d = IDLE;
                            stall_d = '0;
                        end
                    end else if (rdy) begin
                        inc     = 1'b1;
                        state_d = IDLE;
                        stall_d = '0;
                        to_d    = 1'b0;
                    end else if (stall_q != '1) begin
                        stall_d = stall_q + StallW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            // Timeout is raised in the stall cycle that reaches timeout_p.
            // It is raised only once per transaction.
            if (timeout_p != 0 && state_d == PEND && !to_d && stall_d >= TimeoutV) begin
                to_d = 1'b1;
                if (code == CodeNone) code = CodeTimeout;
            end

            cnt_d = cnt_q;
            if (inc && cnt_q != '1) cnt_d = cnt_q + count_width_p'(1);
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                state_q <= IDLE;
                cap_q   <= '0;
                stall_q <= '0;
                to_q    <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cap_q   <= cap_d;
                stall_q <= stall_d;
                to_q    <= to_d;
                cnt_q   <= cnt_d;
            end
        end

        assign chan_code[i] = code;
        assign msg_count_o[i*count_width_p +: count_width_p] = cnt_q;
    end

    // The lowest-indexed violating channel wins.
    logic             any_viol;
    logic [ChanW-1:0] sel_chan;
    logic [1:0]       sel_code;

    always_comb begin
        any_viol = 1'b0;
        sel_chan = '0;
        sel_code = CodeNone;
        for (int k = num_chan_p - 1; k >= 0; k--) begin
            if (chan_code[k] != CodeNone) begin
                any_viol = 1'b1;
                sel_chan = ChanW'(k);
                sel_code = chan_code[k];
            end
        end
    end

    logic             error_q;
    logic [ChanW-1:0] err_chan_q;
    logic [1:0]       err_code_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_q    <= 1'b0;
            err_chan_q <= '0;
            err_code_q <= CodeNone;
        end else begin
            for (int k = 0; k < num_chan_p; k++) begin
                if (chan_code[k] != CodeNone)
                    $display("[%t] if_monitor ch%0d code%0d", $time, k, chan_code[k]);
            end
            if (!error_q && any_viol) begin
                error_q    <= 1'b1;
                err_chan_q <= sel_chan;
                err_code_q <= sel_code;
`ifdef BP_IF_MONITOR_FATAL_EN
                $fatal(1, "if_monitor: first violation ch%0d code%0d", sel_chan, sel_code);
`else
`endif
            end
        end
    end

    assign error_o    = error_q;
    assign err_chan_o = err_chan_q;
    assign err_code_o = err_code_q;

endmodule
